// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling; define UART_RX_PARITY_EN to add an even-parity bit (8E1).
module uart_rx #(
  parameter int CLK_HZ   = 12000000,
  parameter int BAUD     = 9600,
  parameter int CNT_SIZE = 11
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int BIT_TICKS = CLK_HZ / BAUD;
  localparam int HALF = BIT_TICKS / 2;
  localparam logic [CNT_SIZE-1:0] HALF_M1 = CNT_SIZE'(HALF - 1);
  localparam logic [CNT_SIZE-1:0] BIT_M1 = CNT_SIZE'(BIT_TICKS - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t state_q;
  logic sync_q, rx_s_q, rx_p_q;
  logic [CNT_SIZE-1:0] cnt_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q, data_q;
  logic par_err_q, valid_q, frame_err_q, parity_err_q;
  wire bit_end = cnt_q == BIT_M1;
  assign data = data_q;
  assign valid = valid_q;
  assign frame_err = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy = state_q != IDLE;
  always_ff @(posedge clk_in) begin
    if (rst) begin
      {sync_q, rx_s_q, rx_p_q} <= 3'b111;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      {par_err_q, valid_q, frame_err_q, parity_err_q} <= '0;
    end else begin
      {sync_q, rx_s_q, rx_p_q} <= {rx, sync_q, rx_s_q};
      {valid_q, frame_err_q, parity_err_q} <= '0;
      case (state_q)
        IDLE: if (rx_p_q && !rx_s_q) begin
          state_q <= START;
          cnt_q <= '0;
        end
        START: if (cnt_q == HALF_M1) begin
          // a line back high at mid start bit was a glitch, not a frame
          state_q <= rx_s_q ? IDLE : DATA;
          cnt_q <= '0;
          bit_idx_q <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        DATA: if (bit_end) begin
          shift_q[bit_idx_q] <= rx_s_q;
          bit_idx_q <= bit_idx_q + 3'd1;
          cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_q <= PARITY;
`else
          if (bit_idx_q == 3'd7) state_q <= STOP;
`endif
        end else cnt_q <= cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        PARITY: if (bit_end) begin
          par_err_q <= rx_s_q != ^shift_q;
          state_q <= STOP;
          cnt_q <= '0;
        end else cnt_q <= cnt_q + 1'b1;
`endif
        STOP: if (bit_end) begin
          state_q <= IDLE;
          cnt_q <= '0;
          if (!rx_s_q) frame_err_q <= 1'b1;
          else if (par_err_q) parity_err_q <= 1'b1;
          else begin
            data_q <= shift_q;
            valid_q <= 1'b1;
          end
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
